// File: rtl/framebuffer_arbiter.sv
// Double-buffered framebuffer arbiter: display reads front RAM, renderer/clear engine writes back RAM.
// Latency: disp_data valid 1 cycle after disp_addr; renderer writes land in the accept cycle.
// Backpressure: wr_ready drops from swap request until the swap (and optional clear) completes.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   frame_start               one-cycle pulse at start of vertical blank (swap point)
//   disp_addr / disp_data     display read port, 1-cycle latency
//   wr_valid/wr_ready/wr_addr/wr_data   renderer write port into the back buffer
//   swap_req, clear_en        request front/back exchange, optionally clearing the new back buffer
//   front_sel, swap_pending, busy       status
//   ram0_* / ram1_*           the two synchronous-read framebuffer RAMs
module framebuffer_arbiter #(
  parameter int unsigned FB_DEPTH    = 384000,
  parameter int unsigned ADDR_W      = 19,
  parameter logic [3:0]  CLEAR_INDEX = 4'd15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [3:0]        disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              swap_req,
  input  logic              clear_en,
  output logic              front_sel,
  output logic              swap_pending,
  output logic              busy,
  output logic [ADDR_W-1:0] ram0_addr,
  output logic              ram0_we,
  output logic [3:0]        ram0_wdata,
  input  logic [3:0]        ram0_rdata,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic              ram1_we,
  output logic [3:0]        ram1_wdata,
  input  logic [3:0]        ram1_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SWAP = 2'd1,
    ST_CLEAR     = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  state_e            state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic              front_sel_dly_q;   // front_sel as seen by the RAM read issued last cycle
  logic              clr_pend_q, clr_pend_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // Back-buffer port, steered to whichever RAM is not front.
  logic [ADDR_W-1:0] back_addr;
  logic              back_we;
  logic [3:0]        back_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      front_sel_q     <= 1'b0;
      front_sel_dly_q <= 1'b0;
      clr_pend_q      <= 1'b0;
      clr_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      front_sel_q     <= front_sel_d;
      front_sel_dly_q <= front_sel_q;
      clr_pend_q      <= clr_pend_d;
      clr_cnt_q       <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    front_sel_d  = front_sel_q;
    clr_pend_d   = clr_pend_q;
    clr_cnt_d    = clr_cnt_q;
    back_addr    = '0;
    back_we      = 1'b0;
    back_wdata   = 4'd0;
    wr_ready     = 1'b0;
    swap_pending = 1'b0;
    busy         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          // Out-of-range writes complete the handshake but never reach the RAM.
          back_addr  = wr_addr;
          back_wdata = wr_data;
          back_we    = (wr_addr <= LAST_ADDR);
        end
        if (swap_req) begin
          // A frame_start in this same cycle is deliberately not honoured.
          clr_pend_d = clear_en;
          state_d    = ST_WAIT_SWAP;
        end
      end

      ST_WAIT_SWAP: begin
        swap_pending = 1'b1;
        if (frame_start) begin
          front_sel_d = ~front_sel_q;
          state_d     = clr_pend_q ? ST_CLEAR : ST_IDLE;
        end
      end

      ST_CLEAR: begin
        // front_sel has already toggled, so the back port now targets the old front buffer.
        busy       = 1'b1;
        back_addr  = clr_cnt_q;
        back_wdata = CLEAR_INDEX;
        back_we    = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Front RAM sees only display reads; back RAM sees only renderer/clear traffic.
  assign ram0_addr  = front_sel_q ? back_addr  : disp_addr;
  assign ram0_we    = front_sel_q ? back_we    : 1'b0;
  assign ram0_wdata = front_sel_q ? back_wdata : 4'd0;
  assign ram1_addr  = front_sel_q ? disp_addr  : back_addr;
  assign ram1_we    = front_sel_q ? 1'b0       : back_we;
  assign ram1_wdata = front_sel_q ? 4'd0       : back_wdata;

  // Select with the delayed copy so read data stays aligned with its address across a swap.
  assign disp_data  = front_sel_dly_q ? ram1_rdata : ram0_rdata;
  assign front_sel  = front_sel_q;

endmodule
